// File: rtl/ether_bus_bridge.sv
// ether_bus_bridge: decodes an MSB-first dibit stream (ethclk domain) into
// up to MAX_WORDS {address, data} write transactions per frame and drives
// them onto the manta bus-input port. A partial word at frame end is a
// truncation error. Dibits beyond MAX_WORDS words are an overflow error.
// Both errors pulse err_o once and bump a saturating drop counter.
// Optional feature macro: ETHER_BUS_BRIDGE_AUTOINC_EN. When defined, only the
// first word of a frame carries an address, and later words carry data only.
// Their address is the previous address plus one.
module ether_bus_bridge #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MAX_WORDS  = 4,
   parameter int DROP_CNT_W = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             axiiv,
   input  logic [1:0]                       axiid,
   output logic [ADDR_W-1:0]                addr_o,
   output logic [DATA_W-1:0]                data_o,
   output logic                             rw_o,
   output logic                             valid_o,
   output logic [$clog2(MAX_WORDS+1)-1:0]   words_o,
   output logic                             err_o,
   output logic [DROP_CNT_W-1:0]            drop_cnt_o
);

   localparam int HALF_A  = ADDR_W / 2;
   localparam int HALF_D  = DATA_W / 2;
   localparam int HMAX    = (HALF_A > HALF_D) ? HALF_A : HALF_D;
   localparam int CNT_W   = $clog2(HMAX + 1);
   localparam int WORDS_W = $clog2(MAX_WORDS + 1);

   localparam logic [CNT_W-1:0]   A_LAST  = CNT_W'(HALF_A - 1);
   localparam logic [CNT_W-1:0]   D_LAST  = CNT_W'(HALF_D - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [WORDS_W-1:0] W_LAST  = WORDS_W'(MAX_WORDS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
   // later words in a burst are data-only
   localparam state_t AFTER_WORD = DATA;
`else
   localparam state_t AFTER_WORD = ADDR;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic               shift_a, shift_d, emit, err_set, clr_words;
   logic [ADDR_W-1:0]  addr_sr;
   logic [DATA_W-1:0]  data_sr;

   // Saturating increment for the errored-frame counter.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_CNT_W'(1);
   endfunction

   // Left shift, with the new dibit entering the LSBs.
   function automatic logic [ADDR_W-1:0] push_a(input logic [ADDR_W-1:0] sr,
                                                input logic [1:0] d);
      return ADDR_W'({sr, d});
   endfunction

   function automatic logic [DATA_W-1:0] push_d(input logic [DATA_W-1:0] sr,
                                                input logic [1:0] d);
      return DATA_W'({sr, d});
   endfunction

   // FSM state, dibit counter and overflow flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state decode and per-cycle datapath strobes
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      shift_a   = 1'b0;
      shift_d   = 1'b0;
      emit      = 1'b0;
      err_set   = 1'b0;
      clr_words = 1'b0;
      case (state_q)
         IDLE: begin
            if (axiiv) begin
               clr_words = 1'b1;
               shift_a   = 1'b1;
               ovf_d     = 1'b0;
               if (HALF_A == 1) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end else begin
                  state_d = ADDR;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ADDR: begin
            if (axiiv) begin
               shift_a = 1'b1;
               if (cnt_q == A_LAST) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               // an empty address field means the frame ended on a word boundary
               state_d = IDLE;
               cnt_d   = '0;
               err_set = (cnt_q != '0);
            end
         end
         DATA: begin
            if (axiiv) begin
               shift_d = 1'b1;
               if (cnt_q == D_LAST) begin
                  emit  = 1'b1;
                  cnt_d = '0;
                  if (words_o == W_LAST) state_d = DROP;
                  else                   state_d = AFTER_WORD;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
               // ending on a burst word boundary is clean
               err_set = (cnt_q != '0) || (words_o == '0);
`else
               err_set = 1'b1;
`endif
            end
         end
         DROP: begin
            if (axiiv) begin
               ovf_d = 1'b1;
            end else begin
               state_d = IDLE;
               err_set = ovf_q;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end
      endcase
   end

   // Shift registers, transaction outputs, word count and error counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_sr    <= '0;
         data_sr    <= '0;
         addr_o     <= '0;
         data_o     <= '0;
         rw_o       <= 1'b0;
         valid_o    <= 1'b0;
         words_o    <= '0;
         err_o      <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         rw_o    <= 1'b1;
         valid_o <= emit;
         err_o   <= err_set;
         if (shift_a) addr_sr <= push_a(addr_sr, axiid);
         if (shift_d) data_sr <= push_d(data_sr, axiid);
         if (clr_words)  words_o <= '0;
         else if (emit)  words_o <= words_o + WORDS_W'(1);
         if (emit) begin
            data_o <= push_d(data_sr, axiid);
`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
            addr_o <= (words_o == '0) ? addr_sr : addr_o + ADDR_W'(1);
`else
            addr_o <= addr_sr;
`endif
         end
         if (err_set) drop_cnt_o <= sat_inc(drop_cnt_o);
      end
   end

endmodule

// File: tb/tb_ether_bus_bridge.sv
// Testbench for ether_bus_bridge (ADDR_W=16, DATA_W=16, MAX_WORDS=4).
// Directed frames from the test plan plus randomized frames that are checked
// against a dibit-count reference model of the frame rules.
module tb_ether_bus_bridge;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int MAX_WORDS  = 4;
   localparam int DROP_CNT_W = 16;
   localparam int WW         = $clog2(MAX_WORDS + 1);
   localparam int FIRST      = (ADDR_W + DATA_W) / 2;
`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
   localparam int NEXT       = DATA_W / 2;
`else
   localparam int NEXT       = (ADDR_W + DATA_W) / 2;
`endif

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  axiiv = 1'b0;
   logic [1:0]            axiid = 2'b00;
   logic [ADDR_W-1:0]     addr_o;
   logic [DATA_W-1:0]     data_o;
   logic                  rw_o;
   logic                  valid_o;
   logic [WW-1:0]         words_o;
   logic                  err_o;
   logic [DROP_CNT_W-1:0] drop_cnt_o;

   ether_bus_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .DROP_CNT_W(DROP_CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
      .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
      .words_o(words_o), .err_o(err_o), .drop_cnt_o(drop_cnt_o)
   );

   always #10 clk = ~clk;

   int          nvec = 0;
   int          nmis = 0;
   int          ncyc = 0;
   int          start_n, last_n;
   logic [1:0]  frm[$];
   logic [31:0] got_v[$];
   int          got_t[$];
   int          err_t[$];
   logic [31:0] exp_v[$];
   logic        exp_err;
   int          exp_words;
   int          exp_drop = 0;
   logic [31:0] exp_last = 32'h0;

   // observe strobes on the falling edge, tagged with a falling-edge index
   always @(negedge clk) begin
      ncyc = ncyc + 1;
      if (valid_o) begin
         got_v.push_back({addr_o, data_o});
         got_t.push_back(ncyc);
      end
      if (err_o) err_t.push_back(ncyc);
   end

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int i = 15; i >= 0; i--) frm.push_back(w[2*i +: 2]);
   endtask

   task automatic add_half(input logic [15:0] w);
      for (int i = 7; i >= 0; i--) frm.push_back(w[2*i +: 2]);
   endtask

   // drive frm as one frame, then hold axiiv low for gap cycles
   task automatic drive_frame(input int gap, input bit clr);
      if (clr) begin
         got_v.delete(); got_t.delete(); err_t.delete();
      end
      start_n = ncyc;
      foreach (frm[i]) begin
         axiiv = 1'b1;
         axiid = frm[i];
         tick();
      end
      last_n = ncyc;
      axiiv = 1'b0;
      axiid = 2'b00;
      repeat (gap) tick();
   endtask

   // reference: whole words fit in the frame, capped at MAX_WORDS; any dibit
   // not consumed by a complete word marks the frame as errored
   task automatic run_model();
      int n, full, used;
      logic [31:0] v;
      logic [15:0] a;
      exp_v.delete();
      n = frm.size();
      v = 32'h0;
      if (n < FIRST) full = 0;
      else           full = 1 + (n - FIRST) / NEXT;
      if (full > MAX_WORDS) full = MAX_WORDS;
      used = (full == 0) ? 0 : FIRST + (full - 1) * NEXT;
      for (int k = 0; k < full; k++) begin
         if (k == 0 || NEXT == FIRST) begin
            v = 32'h0;
            for (int j = 0; j < FIRST; j++) v = {v[29:0], frm[(k == 0 ? 0 : FIRST + (k - 1) * NEXT) + j]};
         end else begin
            a = v[31:16] + 16'd1;
            v = {a, 16'h0};
            for (int j = 0; j < NEXT; j++) v[15:0] = {v[13:0], frm[FIRST + (k - 1) * NEXT + j]};
         end
         exp_v.push_back(v);
      end
      exp_err   = (n != used);
      exp_words = full;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      nvec++; if (addr_o !== 16'h0)    begin nmis++; $display("FAIL reset_addr got %h want 0000", addr_o); end
      nvec++; if (data_o !== 16'h0)    begin nmis++; $display("FAIL reset_data got %h want 0000", data_o); end
      nvec++; if (rw_o !== 1'b0)       begin nmis++; $display("FAIL reset_rw got %b want 0", rw_o); end
      nvec++; if (valid_o !== 1'b0)    begin nmis++; $display("FAIL reset_valid got %b want 0", valid_o); end
      nvec++; if (words_o !== '0)      begin nmis++; $display("FAIL reset_words got %0d want 0", words_o); end
      nvec++; if (err_o !== 1'b0)      begin nmis++; $display("FAIL reset_err got %b want 0", err_o); end
      nvec++; if (drop_cnt_o !== '0)   begin nmis++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
      rst = 1'b0;
      tick();
      nvec++; if (rw_o !== 1'b1)       begin nmis++; $display("FAIL rw_after_reset got %b want 1", rw_o); end
      tick();
   endtask

   task automatic test_one_word();
      frm.delete();
      add_word(32'h1234ABCD);
      drive_frame(3, 1'b1);
      nvec++; if (got_v.size() != 1) begin nmis++; $display("FAIL one_word_count got %0d want 1", got_v.size()); end
      if (got_v.size() > 0) begin
         nvec++; if (got_v[0] !== 32'h1234ABCD) begin nmis++; $display("FAIL one_word_value got %h want 1234abcd", got_v[0]); end
         nvec++; if (got_t[0] != last_n + 1) begin nmis++; $display("FAIL one_word_latency got %0d want %0d", got_t[0], last_n + 1); end
      end
      nvec++; if (words_o !== WW'(1)) begin nmis++; $display("FAIL one_word_words got %0d want 1", words_o); end
      nvec++; if (err_t.size() != 0)  begin nmis++; $display("FAIL one_word_err got %0d want 0", err_t.size()); end
      nvec++; if ({addr_o, data_o} !== 32'h1234ABCD) begin nmis++; $display("FAIL one_word_hold got %h want 1234abcd", {addr_o, data_o}); end
      exp_last = 32'h1234ABCD;
   endtask

`ifndef ETHER_BUS_BRIDGE_AUTOINC_EN
   task automatic test_three_word();
      logic [31:0] w[3];
      w[0] = 32'h0001_1111; w[1] = 32'h0002_2222; w[2] = 32'h0003_3333;
      frm.delete();
      for (int i = 0; i < 3; i++) add_word(w[i]);
      drive_frame(3, 1'b1);
      nvec++; if (got_v.size() != 3) begin nmis++; $display("FAIL three_word_count got %0d want 3", got_v.size()); end
      for (int i = 0; i < 3 && i < got_v.size(); i++) begin
         nvec++; if (got_v[i] !== w[i]) begin nmis++; $display("FAIL three_word_value[%0d] got %h want %h", i, got_v[i], w[i]); end
         nvec++; if (got_t[i] != start_n + 17 + 16 * i) begin nmis++; $display("FAIL three_word_time[%0d] got %0d want %0d", i, got_t[i], start_n + 17 + 16 * i); end
      end
      nvec++; if (words_o !== WW'(3)) begin nmis++; $display("FAIL three_word_words got %0d want 3", words_o); end
      nvec++; if (err_t.size() != 0)  begin nmis++; $display("FAIL three_word_err got %0d want 0", err_t.size()); end
      exp_last = w[2];
   endtask

   task automatic test_overflow();
      frm.delete();
      for (int i = 1; i <= 5; i++) add_word({4'(i), 12'h000, 12'h000, 4'(i)});
      drive_frame(3, 1'b1);
      exp_drop++;
      nvec++; if (got_v.size() != 4) begin nmis++; $display("FAIL overflow_count got %0d want 4", got_v.size()); end
      for (int i = 0; i < 4 && i < got_v.size(); i++) begin
         nvec++; if (got_v[i] !== {4'(i + 1), 24'h0, 4'(i + 1)}) begin nmis++; $display("FAIL overflow_value[%0d] got %h want %h", i, got_v[i], {4'(i + 1), 24'h0, 4'(i + 1)}); end
      end
      nvec++; if (err_t.size() != 1) begin nmis++; $display("FAIL overflow_err_count got %0d want 1", err_t.size()); end
      if (err_t.size() > 0) begin
         nvec++; if (err_t[0] != last_n + 2) begin nmis++; $display("FAIL overflow_err_time got %0d want %0d", err_t[0], last_n + 2); end
      end
      nvec++; if (words_o !== WW'(4)) begin nmis++; $display("FAIL overflow_words got %0d want 4", words_o); end
      nvec++; if (int'(drop_cnt_o) != exp_drop) begin nmis++; $display("FAIL overflow_drop got %0d want %0d", drop_cnt_o, exp_drop); end
      exp_last = 32'h4000_0004;
   endtask
`endif

   task automatic test_truncated();
      frm.delete();
      for (int i = 0; i < 10; i++) frm.push_back(2'($urandom));
      drive_frame(3, 1'b1);
      exp_drop++;
      nvec++; if (got_v.size() != 0) begin nmis++; $display("FAIL trunc_valid got %0d want 0", got_v.size()); end
      nvec++; if (err_t.size() != 1) begin nmis++; $display("FAIL trunc_err_count got %0d want 1", err_t.size()); end
      if (err_t.size() > 0) begin
         nvec++; if (err_t[0] != last_n + 2) begin nmis++; $display("FAIL trunc_err_time got %0d want %0d", err_t[0], last_n + 2); end
      end
      nvec++; if (int'(drop_cnt_o) != exp_drop) begin nmis++; $display("FAIL trunc_drop got %0d want %0d", drop_cnt_o, exp_drop); end
      nvec++; if ({addr_o, data_o} !== exp_last) begin nmis++; $display("FAIL trunc_hold got %h want %h", {addr_o, data_o}, exp_last); end
      nvec++; if (words_o !== '0) begin nmis++; $display("FAIL trunc_words got %0d want 0", words_o); end
   endtask

   task automatic test_back_to_back();
      frm.delete();
      add_word(32'hA5A5_0F0F);
      drive_frame(1, 1'b1);
      frm.delete();
      add_word(32'h5A5A_F0F0);
      drive_frame(3, 1'b0);
      nvec++; if (got_v.size() != 2) begin nmis++; $display("FAIL b2b_count got %0d want 2", got_v.size()); end
      if (got_v.size() == 2) begin
         nvec++; if (got_v[0] !== 32'hA5A5_0F0F) begin nmis++; $display("FAIL b2b_first got %h want a5a50f0f", got_v[0]); end
         nvec++; if (got_v[1] !== 32'h5A5A_F0F0) begin nmis++; $display("FAIL b2b_second got %h want 5a5af0f0", got_v[1]); end
         nvec++; if (got_t[1] - got_t[0] != FIRST + 1) begin nmis++; $display("FAIL b2b_spacing got %0d want %0d", got_t[1] - got_t[0], FIRST + 1); end
      end
      nvec++; if (err_t.size() != 0)  begin nmis++; $display("FAIL b2b_err got %0d want 0", err_t.size()); end
      nvec++; if (words_o !== WW'(1)) begin nmis++; $display("FAIL b2b_words got %0d want 1", words_o); end
      exp_last = 32'h5A5A_F0F0;
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 40; it++) begin
         frm.delete();
         if ($urandom_range(0, 1) == 0) n = FIRST + NEXT * $urandom_range(0, MAX_WORDS - 1);
         else                           n = $urandom_range(1, FIRST + NEXT * MAX_WORDS + 10);
         for (int i = 0; i < n; i++) frm.push_back(2'($urandom));
         run_model();
         drive_frame($urandom_range(2, 4), 1'b1);
         if (exp_err) exp_drop++;
         if (exp_v.size() > 0) exp_last = exp_v[exp_v.size() - 1];
         nvec++; if (got_v.size() != exp_v.size()) begin nmis++; $display("FAIL rand%0d_count got %0d want %0d", it, got_v.size(), exp_v.size()); end
         for (int k = 0; k < exp_v.size() && k < got_v.size(); k++) begin
            nvec++; if (got_v[k] !== exp_v[k]) begin nmis++; $display("FAIL rand%0d_value[%0d] got %h want %h", it, k, got_v[k], exp_v[k]); end
            nvec++; if (got_t[k] != start_n + 1 + FIRST + k * NEXT) begin nmis++; $display("FAIL rand%0d_time[%0d] got %0d want %0d", it, k, got_t[k], start_n + 1 + FIRST + k * NEXT); end
         end
         nvec++; if (err_t.size() != int'(exp_err)) begin nmis++; $display("FAIL rand%0d_err got %0d want %0d", it, err_t.size(), exp_err); end
         nvec++; if (int'(words_o) != exp_words) begin nmis++; $display("FAIL rand%0d_words got %0d want %0d", it, words_o, exp_words); end
         nvec++; if (int'(drop_cnt_o) != exp_drop) begin nmis++; $display("FAIL rand%0d_drop got %0d want %0d", it, drop_cnt_o, exp_drop); end
         nvec++; if ({addr_o, data_o} !== exp_last) begin nmis++; $display("FAIL rand%0d_hold got %h want %h", it, {addr_o, data_o}, exp_last); end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) begin
         axiiv = 1'b1;
         axiid = 2'($urandom);
         tick();
      end
      #3 rst = 1'b1;
      #1;
      nvec++; if ({addr_o, data_o} !== 32'h0) begin nmis++; $display("FAIL arst_addr_data got %h want 0", {addr_o, data_o}); end
      nvec++; if (rw_o !== 1'b0 || valid_o !== 1'b0 || err_o !== 1'b0) begin nmis++; $display("FAIL arst_strobes got rw=%b v=%b e=%b want 0", rw_o, valid_o, err_o); end
      nvec++; if (words_o !== '0 || drop_cnt_o !== '0) begin nmis++; $display("FAIL arst_counts got w=%0d d=%0d want 0", words_o, drop_cnt_o); end
      axiiv = 1'b0;
      axiid = 2'b00;
      tick();
      #4 rst = 1'b0;
      tick(); tick();
      exp_drop = 0;
      frm.delete();
      add_word(32'hBEEF_0042);
      drive_frame(3, 1'b1);
      nvec++; if (got_v.size() != 1) begin nmis++; $display("FAIL arst_frame_count got %0d want 1", got_v.size()); end
      nvec++; if ({addr_o, data_o} !== 32'hBEEF_0042) begin nmis++; $display("FAIL arst_frame_value got %h want beef0042", {addr_o, data_o}); end
      nvec++; if (err_t.size() != 0 || drop_cnt_o !== '0) begin nmis++; $display("FAIL arst_frame_err got %0d/%0d want 0/0", err_t.size(), drop_cnt_o); end
      exp_last = 32'hBEEF_0042;
   endtask

`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
   task automatic test_autoinc();
      frm.delete();
      add_word(32'hFFFF_0001);
      add_half(16'h0002);
      drive_frame(3, 1'b1);
      nvec++; if (got_v.size() != 2) begin nmis++; $display("FAIL autoinc_count got %0d want 2", got_v.size()); end
      if (got_v.size() == 2) begin
         nvec++; if (got_v[0] !== 32'hFFFF_0001) begin nmis++; $display("FAIL autoinc_first got %h want ffff0001", got_v[0]); end
         nvec++; if (got_v[1] !== 32'h0000_0002) begin nmis++; $display("FAIL autoinc_second got %h want 00000002", got_v[1]); end
         nvec++; if (got_t[1] - got_t[0] != 8) begin nmis++; $display("FAIL autoinc_spacing got %0d want 8", got_t[1] - got_t[0]); end
      end
      nvec++; if (err_t.size() != 0)  begin nmis++; $display("FAIL autoinc_err got %0d want 0", err_t.size()); end
      nvec++; if (words_o !== WW'(2)) begin nmis++; $display("FAIL autoinc_words got %0d want 2", words_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_one_word();
`ifndef ETHER_BUS_BRIDGE_AUTOINC_EN
      test_three_word();
`endif
      test_truncated();
`ifndef ETHER_BUS_BRIDGE_AUTOINC_EN
      test_overflow();
`endif
      test_back_to_back();
      test_random();
      test_async_reset();
`ifdef ETHER_BUS_BRIDGE_AUTOINC_EN
      test_autoinc();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
